bike_motion_ctrl: RTL and testbench

// Upstream of the trail writer: owns both light-cycle positions and headings on a 56x56 cell grid.
// - Once every STEP_DIV frames: applies queued steering, steps each bike one cell, checks the

---
 rtl/bike_motion_ctrl_if.sv | 29 ++
 rtl/bike_motion_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_bike_motion_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/bike_motion_ctrl_if.sv
// Steering request and bike state bundle between the motion controller and its
// neighbours (input decoder, trail writer, game FSM).
interface bike_motion_ctrl_if;
    logic       Blue_req_valid;
    logic [1:0] Blue_req_dir;
    logic       Red_req_valid;
    logic [1:0] Red_req_dir;
    logic [7:0] Blue_X;
    logic [7:0] Blue_Y;
    logic [7:0] Red_X;
    logic [7:0] Red_Y;
    logic [1:0] Blue_dir;
    logic [1:0] Red_dir;
    logic       Blue_crash;
    logic       Red_crash;
    logic       step_done;

    modport master (
        output Blue_req_valid, Blue_req_dir, Red_req_valid, Red_req_dir,
        input  Blue_X, Blue_Y, Red_X, Red_Y, Blue_dir, Red_dir,
        input  Blue_crash, Red_crash, step_done
    );

    modport slave (
        input  Blue_req_valid, Blue_req_dir, Red_req_valid, Red_req_dir,
        output Blue_X, Blue_Y, Red_X, Red_Y, Blue_dir, Red_dir,
        output Blue_crash, Red_crash, step_done
    );
endinterface

// File: rtl/bike_motion_ctrl.sv
// Light-cycle motion controller: steps both bikes once every STEP_DIV frames and
// judges walls, trails and head-on hits against a 1-bit cell-occupancy bitmap.
module bike_motion_ctrl #(
    parameter int GRID_W   = 56,
    parameter int GRID_H   = 56,
    parameter int STEP_DIV = 2,
    parameter int BLUE_X0  = 8,
    parameter int BLUE_Y0  = 28,
    parameter int RED_X0   = 47,
    parameter int RED_Y0   = 28
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic [2:0]         Game_State,
    bike_motion_ctrl_if.slave  bus
);
    localparam logic [2:0] PLAYING = 3'b010;
    localparam int CELLS = GRID_W * GRID_H;
    localparam int AW    = $clog2(CELLS);
    localparam int CW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic signed [8:0] XMAX = 9'(GRID_W - 1);
    localparam logic signed [8:0] YMAX = 9'(GRID_H - 1);

    typedef enum logic [3:0] {
        IDLE, CLEAR, MARK_B, MARK_R, WAIT, NEXT, RD_B, RD_R,
        JUDGE, COMMIT_B, COMMIT_R, DEAD
    } state_t;

    function automatic logic signed [8:0] next_x(input logic [7:0] x, input logic [1:0] dir);
        logic signed [8:0] sx;
        sx = $signed({1'b0, x});
        case (dir)
            2'b10:   return sx - 9'sd1;
            2'b11:   return sx + 9'sd1;
            default: return sx;
        endcase
    endfunction

    function automatic logic signed [8:0] next_y(input logic [7:0] y, input logic [1:0] dir);
        logic signed [8:0] sy;
        sy = $signed({1'b0, y});
        case (dir)
            2'b00:   return sy - 9'sd1;
            2'b01:   return sy + 9'sd1;
            default: return sy;
        endcase
    endfunction

    function automatic logic off_grid(input logic signed [8:0] x, input logic signed [8:0] y);
        return (x < 9'sd0) || (x > XMAX) || (y < 9'sd0) || (y > YMAX);
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic signed [8:0] x, input logic signed [8:0] y);
        return AW'(y) * AW'(GRID_W) + AW'(x);
    endfunction

    function automatic logic is_reverse(input logic [1:0] req, input logic [1:0] cur);
        return (req[1] == cur[1]) && (req[0] != cur[0]);
    endfunction

    state_t            state;
    logic [AW-1:0]     clr_addr;
    logic [7:0]        bx, by, rx, ry;
    logic [1:0]        bdir, rdir;
    logic              b_crash, r_crash, step_done;
    logic              pend_b_vld, pend_r_vld;
    logic [1:0]        pend_b_dir, pend_r_dir;
    logic [CW-1:0]     fcnt;
    logic [2:0]        fsync;
    logic signed [8:0] nbx, nby, nrx, nry;
    logic [1:0]        nbdir, nrdir;
    logic              b_wall, r_wall, b_occ;

    logic              f_edge, step_trig, head_on, b_hit, r_hit;
    logic [1:0]        b_dir_app, r_dir_app;

    logic              mem [0:CELLS-1];
    logic              mem_we, mem_wd, mem_re, mem_rd;
    logic [AW-1:0]     mem_addr;

    // frame_clk comes from another domain: two flops to resync, third for the edge
    always_ff @(posedge Clk) begin
        if (Reset) fsync <= '0;
        else       fsync <= {fsync[1:0], frame_clk};
    end

    assign f_edge    = fsync[1] & ~fsync[2];
    assign step_trig = f_edge && (fcnt == CW'(STEP_DIV - 1));
    assign b_dir_app = (pend_b_vld && !is_reverse(pend_b_dir, bdir)) ? pend_b_dir : bdir;
    assign r_dir_app = (pend_r_vld && !is_reverse(pend_r_dir, rdir)) ? pend_r_dir : rdir;
    assign head_on   = (nbx == nrx) && (nby == nry);
    // mem_rd holds the red read in JUDGE; a stale value only matters when r_wall already hits
    assign b_hit     = b_wall | b_occ | head_on;
    assign r_hit     = r_wall | mem_rd | head_on;

    always_comb begin
        mem_we   = 1'b0;
        mem_wd   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = '0;
        case (state)
            CLEAR:    begin mem_we = 1'b1; mem_addr = clr_addr; end
            MARK_B:   begin mem_we = 1'b1; mem_wd = 1'b1; mem_addr = cell_addr(9'(BLUE_X0), 9'(BLUE_Y0)); end
            MARK_R:   begin mem_we = 1'b1; mem_wd = 1'b1; mem_addr = cell_addr(9'(RED_X0), 9'(RED_Y0)); end
            RD_B:     begin mem_re = ~b_wall; mem_addr = cell_addr(nbx, nby); end
            RD_R:     begin mem_re = ~r_wall; mem_addr = cell_addr(nrx, nry); end
            COMMIT_B: begin mem_we = 1'b1; mem_wd = 1'b1; mem_addr = cell_addr(nbx, nby); end
            COMMIT_R: begin mem_we = 1'b1; mem_wd = 1'b1; mem_addr = cell_addr(nrx, nry); end
            default:  ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (mem_we) mem[mem_addr] <= mem_wd;
        if (mem_re) mem_rd <= mem[mem_addr];
    end

    always_ff @(posedge Clk) begin
        if (Reset || (Game_State != PLAYING)) begin
            state      <= IDLE;
            clr_addr   <= '0;
            bx         <= 8'(BLUE_X0);
            by         <= 8'(BLUE_Y0);
            rx         <= 8'(RED_X0);
            ry         <= 8'(RED_Y0);
            bdir       <= 2'b11;
            rdir       <= 2'b10;
            b_crash    <= 1'b0;
            r_crash    <= 1'b0;
            step_done  <= 1'b0;
            pend_b_vld <= 1'b0;
            pend_r_vld <= 1'b0;
            pend_b_dir <= 2'b00;
            pend_r_dir <= 2'b00;
            fcnt       <= '0;
        end else begin
            step_done <= 1'b0;
            // a request landing in NEXT survives for the following step
            if (bus.Blue_req_valid) begin
                pend_b_vld <= 1'b1;
                pend_b_dir <= bus.Blue_req_dir;
            end else if (state == NEXT) begin
                pend_b_vld <= 1'b0;
            end
            if (bus.Red_req_valid) begin
                pend_r_vld <= 1'b1;
                pend_r_dir <= bus.Red_req_dir;
            end else if (state == NEXT) begin
                pend_r_vld <= 1'b0;
            end
            if (f_edge) fcnt <= (fcnt == CW'(STEP_DIV - 1)) ? '0 : fcnt + 1'b1;

            case (state)
                IDLE: begin
                    clr_addr <= '0;
                    state    <= CLEAR;
                end
                CLEAR: begin
                    if (clr_addr == AW'(CELLS - 1)) state <= MARK_B;
                    else                            clr_addr <= clr_addr + 1'b1;
                end
                MARK_B: state <= MARK_R;
                MARK_R: state <= WAIT;
                WAIT:   if (step_trig) state <= NEXT;
                NEXT: begin
                    nbdir  <= b_dir_app;
                    nrdir  <= r_dir_app;
                    nbx    <= next_x(bx, b_dir_app);
                    nby    <= next_y(by, b_dir_app);
                    nrx    <= next_x(rx, r_dir_app);
                    nry    <= next_y(ry, r_dir_app);
                    b_wall <= off_grid(next_x(bx, b_dir_app), next_y(by, b_dir_app));
                    r_wall <= off_grid(next_x(rx, r_dir_app), next_y(ry, r_dir_app));
                    state  <= RD_B;
                end
                RD_B: state <= RD_R;
                RD_R: begin
                    b_occ <= mem_rd;
                    state <= JUDGE;
                end
                JUDGE: begin
                    if (b_hit || r_hit) begin
                        b_crash <= b_hit;
                        r_crash <= r_hit;
                        state   <= DEAD;
                    end else begin
                        state <= COMMIT_B;
                    end
                end
                COMMIT_B: state <= COMMIT_R;
                COMMIT_R: begin
                    bx        <= nbx[7:0];
                    by        <= nby[7:0];
                    rx        <= nrx[7:0];
                    ry        <= nry[7:0];
                    bdir      <= nbdir;
                    rdir      <= nrdir;
                    step_done <= 1'b1;
                    state     <= WAIT;
                end
                DEAD:    state <= DEAD;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Blue_X     = bx;
    assign bus.Blue_Y     = by;
    assign bus.Red_X      = rx;
    assign bus.Red_Y      = ry;
    assign bus.Blue_dir   = bdir;
    assign bus.Red_dir    = rdir;
    assign bus.Blue_crash = b_crash;
    assign bus.Red_crash  = r_crash;
    assign bus.step_done  = step_done;
endmodule

// File: tb/tb_bike_motion_ctrl.sv
// Directed bench for bike_motion_ctrl: default-start instance plus a close-start
// instance that drives the two bikes into a head-on collision.
module tb_bike_motion_ctrl;
    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [2:0] Game_State;

    bike_motion_ctrl_if bif ();
    bike_motion_ctrl_if bifh ();

    bike_motion_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .Game_State (Game_State),
        .bus        (bif)
    );

    bike_motion_ctrl #(.RED_X0(12)) dut_h (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .Game_State (Game_State),
        .bus        (bifh)
    );

    always #10 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int steps  = 0;
    int split  = 0;
    int s0;

    always @(posedge Clk) begin
        if (bif.step_done) steps <= steps + 1;
        if (bifh.Blue_crash != bifh.Red_crash) split <= split + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic frame_edge();
        frame_clk = 1'b1;
        cyc(4);
        frame_clk = 1'b0;
        cyc(4);
    endtask

    task automatic do_step();
        frame_edge();
        frame_edge();
        cyc(12);
    endtask

    task automatic req_blue(input logic [1:0] dir);
        bif.Blue_req_valid = 1'b1;
        bif.Blue_req_dir   = dir;
        cyc(1);
        bif.Blue_req_valid = 1'b0;
    endtask

    task automatic new_game();
        Game_State = 3'b000;
        cyc(2);
        Game_State = 3'b010;
        cyc(3200);
    endtask

    initial begin
        Reset      = 1'b1;
        Game_State = 3'b010;
        frame_clk  = 1'b0;
        bif.Blue_req_valid  = 1'b0;
        bif.Blue_req_dir    = 2'b00;
        bif.Red_req_valid   = 1'b0;
        bif.Red_req_dir     = 2'b00;
        bifh.Blue_req_valid = 1'b0;
        bifh.Blue_req_dir   = 2'b00;
        bifh.Red_req_valid  = 1'b0;
        bifh.Red_req_dir    = 2'b00;
        cyc(2);

        check("rst_blue_x", bif.Blue_X, 8);
        check("rst_blue_y", bif.Blue_Y, 28);
        check("rst_blue_dir", bif.Blue_dir, 3);
        check("rst_red_x", bif.Red_X, 47);
        check("rst_red_y", bif.Red_Y, 28);
        check("rst_red_dir", bif.Red_dir, 2);
        check("rst_crash", {bif.Blue_crash, bif.Red_crash}, 0);
        check("rst_step_done", bif.step_done, 0);
        Reset = 1'b0;

        // edges during the bitmap clear must not move anything
        cyc(100);
        repeat (4) frame_edge();
        check("clear_drops_steps", steps, 0);
        cyc(3100);
        check("clear_blue_x", bif.Blue_X, 8);

        do_step();
        do_step();
        check("two_steps_count", steps, 2);
        check("two_steps_blue_x", bif.Blue_X, 10);
        check("two_steps_blue_y", bif.Blue_Y, 28);
        check("two_steps_red_x", bif.Red_X, 45);
        check("two_steps_red_y", bif.Red_Y, 28);

        check("headon_crash", {bifh.Blue_crash, bifh.Red_crash}, 3);
        check("headon_blue_x", bifh.Blue_X, 9);
        check("headon_red_x", bifh.Red_X, 11);
        check("headon_same_cycle", split, 0);

        req_blue(2'b10);
        do_step();
        check("reverse_blue_dir", bif.Blue_dir, 3);
        check("reverse_blue_x", bif.Blue_X, 11);
        check("reverse_count", steps, 3);

        req_blue(2'b01);
        req_blue(2'b00);
        bif.Red_req_valid = 1'b1;
        bif.Red_req_dir   = 2'b01;
        cyc(1);
        bif.Red_req_valid = 1'b0;
        do_step();
        check("lastwins_blue_dir", bif.Blue_dir, 0);
        check("lastwins_blue_y", bif.Blue_Y, 27);
        check("lastwins_blue_x", bif.Blue_X, 11);
        check("red_down_dir", bif.Red_dir, 1);
        check("red_down_xy", {bif.Red_X, bif.Red_Y}, {8'd44, 8'd29});
        check("lastwins_count", steps, 4);

        new_game();
        s0 = steps;
        req_blue(2'b00);
        repeat (29) do_step();
        check("wall_count", steps - s0, 28);
        check("wall_crash", {bif.Blue_crash, bif.Red_crash}, 2);
        check("wall_blue_xy", {bif.Blue_X, bif.Blue_Y}, {8'd8, 8'd0});
        check("wall_red_xy", {bif.Red_X, bif.Red_Y}, {8'd19, 8'd28});
        do_step();
        check("dead_count", steps - s0, 28);
        check("dead_red_x", bif.Red_X, 19);

        new_game();
        s0 = steps;
        do_step();
        req_blue(2'b01);
        do_step();
        req_blue(2'b10);
        do_step();
        req_blue(2'b00);
        do_step();
        check("trail_count", steps - s0, 3);
        check("trail_crash", {bif.Blue_crash, bif.Red_crash}, 2);
        check("trail_blue_xy", {bif.Blue_X, bif.Blue_Y}, {8'd8, 8'd29});
        check("trail_blue_dir", bif.Blue_dir, 2);
        check("trail_red_x", bif.Red_X, 44);

        Game_State = 3'b000;
        cyc(1);
        check("leave_crash", {bif.Blue_crash, bif.Red_crash}, 0);
        check("leave_blue_xy", {bif.Blue_X, bif.Blue_Y}, {8'd8, 8'd28});
        check("leave_blue_dir", bif.Blue_dir, 3);

        Game_State = 3'b010;
        cyc(500);
        Game_State = 3'b000;
        cyc(1);
        check("abort_red_xy", {bif.Red_X, bif.Red_Y}, {8'd47, 8'd28});
        Game_State = 3'b010;
        cyc(3200);
        s0 = steps;
        do_step();
        check("replay_count", steps - s0, 1);
        check("replay_blue_x", bif.Blue_X, 9);
        check("replay_crash", {bif.Blue_crash, bif.Red_crash}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
